branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch predictor and resolver for the RV32I pipeline. In IF it indexes a direct-mapped branch target buffer (BTB) with per-entry saturating counters and supplies a predicted direction and target. In EX it resolves the branch from operands and `br_type`, flags mispredictions with the redirect PC, and trains the table. It replaces the purely combinational EX-stage branch decision.

## Interface
- `XLEN`, default 32: data/PC width.
- `ENTRIES`, default 64: BTB depth; power of two, ≥2. `IDX_W = log2(ENTRIES)`, `TAG_W = XLEN-2-IDX_W`.
- `CNT_W`, default 2: counter width, ≥1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_pc` in XLEN: fetch PC.
- `pred_taken` out 1: predicted taken.
- `pred_target` out XLEN: predicted next PC.
- `ex_valid` in 1: EX holds a valid instruction; caller deasserts on stall/flush.
- `ex_pc` in XLEN: PC of the EX instruction.
- `ex_br_type` in 3: branch type (shared `NOBRANCH/BEQ/BNE/BLT/BLTU/BGE/BGEU` codes).
- `ex_reg1`, `ex_reg2` in XLEN: compare operands.
- `ex_target` in XLEN: computed branch target.
- `ex_pred_taken` in 1, `ex_pred_target` in XLEN: IF prediction piped to EX.
- `ex_br` out 1: resolved taken.
- `ex_mispredict` out 1: flush/redirect request.
- `ex_redirect_pc` out XLEN: correct next PC.
- `stat_branches`, `stat_mispredicts` out 32: statistics (see Configuration).

## Operation
- Index `pc[IDX_W+1:2]`; tag `pc[XLEN-1:IDX_W+2]`. Per entry: valid, tag, target, counter.
- Lookup: `hit = valid[idx] && tag==tag[idx]`. `pred_taken = hit && cnt[idx][CNT_W-1]`. `pred_target = pred_taken ? target[idx] : if_pc+4`, modulo 2^XLEN.
- Resolve: BEQ/BNE equality; BLT/BGE signed; BLTU/BGEU unsigned; NOBRANCH and undefined codes give `ex_br=0`.
- `ex_redirect_pc = ex_br ? ex_target : ex_pc+4`.
- `ex_mispredict = ex_valid && (ex_br != ex_pred_taken || (ex_br && ex_pred_target != ex_target))`. This includes NOBRANCH with `ex_pred_taken=1`, which redirects to `ex_pc+4`.
- Train only when `ex_valid && ex_br_type != NOBRANCH`, re-looking up `ex_pc`:
  - Hit: counter saturating +1 if taken, −1 if not; no wrap at all-ones or zero. Target rewritten when taken.
  - Miss and taken: allocate (overwrite); valid=1, tag, target=`ex_target`, counter=weakly taken (`1<<(CNT_W-1)`).
  - Miss and not taken: no change.
- Reset: all valid bits 0 and counters set to weakly not-taken (`(1<<(CNT_W-1))-1`; 0 when CNT_W=1). Tags and targets are not reset.
- While `rst_n`=0: `pred_taken=0`, `ex_mispredict=0`, no training. An update coincident with reset is discarded.

## Timing
- Lookup and resolve are combinational, with 0-cycle latency.
- Training writes at the rising edge ending the EX cycle. A lookup in the next cycle sees the new value.
- Same-cycle IF lookup and EX update to the same index: the lookup returns the pre-update contents.
- Back-to-back updates to one entry in consecutive cycles each apply in order; nothing is lost.
- Reset takes effect at the first rising edge with `rst_n`=0. Lookups hit nothing until trained.

## Configuration
- `BP_STATS_EN` defined: two 32-bit counters, reset to 0.
  - `stat_branches` increments on every training event.
  - `stat_mispredicts` increments on every `ex_mispredict`.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports remain; both tied to 0; no flops.

## Structure
- Shared package/header: `br_type` codes (existing), counter init constants, saturating inc/dec function.
- Sub-module `branch_compare` (param XLEN): combinational `reg1/reg2/br_type -> br`. The main block holds the BTB arrays and update logic.

## Test plan
- Reset, then `if_pc=0x100` -> `pred_taken=0`, `pred_target=0x104`.
- BEQ at 0x100, reg1=reg2=5, target 0x80, pred 0 -> `ex_br=1`, `ex_mispredict=1`, redirect 0x80. Next cycle, lookup 0x100 -> taken, 0x80.
- BLT reg1=0xFFFFFFFF, reg2=1 -> `ex_br=1`; BLTU with same operands -> `ex_br=0`.
- Train taken 3× on one entry -> counter stays 11. Then 2 not-taken -> 01, and lookup gives `pred_taken=0`.
- Aliasing: PC 0x100 and 0x100+4·ENTRIES both taken -> second evicts first; lookup 0x100 misses.
- Same-cycle EX allocate and IF lookup at 0x100 -> lookup misses; next cycle hits. `BP_STATS_EN`: counts 1 branch, 1 mispredict.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
//   br_type_e          : EX-stage branch type codes (NOBRANCH/BEQ/BNE/BLT/BLTU/BGE/BGEU)
//   CNT_MAX_W          : widest counter the helper functions support
//   cnt_weak_taken     : counter init value on allocation
//   cnt_weak_not_taken : counter value after reset
//   cnt_step           : saturating +1 / -1 of a counter of a given width
package branch_predictor_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } br_type_e;

    localparam int unsigned CNT_MAX_W = 16;

    function automatic logic [CNT_MAX_W-1:0] cnt_weak_taken(input int unsigned w);
        return CNT_MAX_W'(1) << (w - 1);
    endfunction

    // (1 << (w-1)) - 1, which is 0 for a 1-bit counter
    function automatic logic [CNT_MAX_W-1:0] cnt_weak_not_taken(input int unsigned w);
        return (CNT_MAX_W'(1) << (w - 1)) - CNT_MAX_W'(1);
    endfunction

    // Saturating step; the counter occupies the low w bits
    function automatic logic [CNT_MAX_W-1:0] cnt_step(input logic [CNT_MAX_W-1:0] c,
                                                      input logic                 up,
                                                      input int unsigned          w);
        logic [CNT_MAX_W-1:0] top;
        top = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - w);
        if (up) begin
            return (c == top) ? c : c + CNT_MAX_W'(1);
        end
        return (c == '0) ? c : c - CNT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_compare.sv
// branch_compare: combinational branch condition evaluation.
//   reg1, reg2 : compare operands (XLEN)
//   br_type    : branch type code
//   br         : 1 when the branch is taken; NOBRANCH and undefined codes give 0
module branch_compare
    import branch_predictor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [2:0]      br_type,
    output logic            br
);

    always_comb begin
        br = 1'b0;
        case (br_type)
            BEQ:     br = (reg1 == reg2);
            BNE:     br = (reg1 != reg2);
            BLT:     br = ($signed(reg1) <  $signed(reg2));
            BGE:     br = ($signed(reg1) >= $signed(reg2));
            BLTU:    br = (reg1 <  reg2);
            BGEU:    br = (reg1 >= reg2);
            default: br = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters (IF lookup)
// plus EX-stage branch resolution, misprediction detection and training.
//   clk, rst_n         : clock (rising edge), synchronous active-low reset
//   if_pc              : fetch PC; pred_taken / pred_target are its prediction
//   ex_*               : EX instruction, operands, computed target, piped prediction
//   ex_br              : resolved direction
//   ex_mispredict      : redirect request; ex_redirect_pc is the correct next PC
//   stat_branches/stat_mispredicts : saturating statistics counters
// Optional feature macro: BP_STATS_EN (statistics counters; tied to 0 otherwise).
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_br_type,
    input  logic [XLEN-1:0] ex_reg1,
    input  logic [XLEN-1:0] ex_reg2,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_br,
    output logic            ex_mispredict,
    output logic [XLEN-1:0] ex_redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_INIT_T  = CNT_W'(cnt_weak_taken(CNT_W));
    localparam logic [CNT_W-1:0] CNT_INIT_NT = CNT_W'(cnt_weak_not_taken(CNT_W));

    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]   btb_tag    [ENTRIES];
    logic [XLEN-1:0]    btb_target [ENTRIES];
    logic [CNT_W-1:0]   btb_cnt    [ENTRIES];

    // IF lookup
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

    assign pred_taken  = rst_n && if_hit && btb_cnt[if_idx][CNT_W-1];
    assign pred_target = pred_taken ? btb_target[if_idx] : if_pc + XLEN'(4);

    // EX resolve
    branch_compare #(.XLEN(XLEN)) u_cmp (
        .reg1    (ex_reg1),
        .reg2    (ex_reg2),
        .br_type (ex_br_type),
        .br      (ex_br)
    );

    assign ex_redirect_pc = ex_br ? ex_target : ex_pc + XLEN'(4);
    assign ex_mispredict  = rst_n && ex_valid &&
                            ((ex_br != ex_pred_taken) ||
                             (ex_br && (ex_pred_target != ex_target)));

    // EX training
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             train;
    logic [CNT_W-1:0] cnt_next;

    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign ex_tag   = ex_pc[XLEN-1:IDX_W+2];
    assign ex_hit   = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    assign train    = rst_n && ex_valid && (ex_br_type != NOBRANCH);
    assign cnt_next = CNT_W'(cnt_step(CNT_MAX_W'(btb_cnt[ex_idx]), ex_br, CNT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_cnt[i] <= CNT_INIT_NT;
            end
        end else if (train) begin
            if (ex_hit) begin
                btb_cnt[ex_idx] <= cnt_next;
            end else if (ex_br) begin
                btb_valid[ex_idx] <= 1'b1;
                btb_cnt[ex_idx]   <= CNT_INIT_T;
            end
        end
    end

    // Tag and target carry no reset. A taken training event either hits
    // (tag unchanged) or allocates (tag replaced), so writing both covers
    // both cases.
    always_ff @(posedge clk) begin
        if (train && ex_br) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (train && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (ex_mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_br_type;
    logic [31:0] ex_reg1, ex_reg2, ex_target, ex_pred_target;
    logic        ex_pred_taken;
    logic        ex_br, ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [31:0] stat_branches, stat_mispredicts;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_br_type       (ex_br_type),
        .ex_reg1          (ex_reg1),
        .ex_reg2          (ex_reg2),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_br            (ex_br),
        .ex_mispredict    (ex_mispredict),
        .ex_redirect_pc   (ex_redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int unsigned m_nb, m_nm;

    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int CTHRES = 1 << (CNT_W - 1);

    function automatic bit m_resolve(input int t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (t)
            1: return a == b;
            2: return a != b;
            3: return sa < sb;
            4: return a < b;
            5: return sa >= sb;
            6: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_mis();
        bit b;
        b = m_resolve(int'(ex_br_type), ex_reg1, ex_reg2);
        return rst_n && ex_valid &&
               ((b != ex_pred_taken) || (b && ex_pred_target != ex_target));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = CTHRES - 1;
            end
            m_nb = 0;
            m_nm = 0;
        end else begin
            int idx;
            int unsigned tg;
            bit b, hit;
            idx = int'((ex_pc / 4) % ENTRIES);
            tg  = ex_pc / (4 * ENTRIES);
            b   = m_resolve(int'(ex_br_type), ex_reg1, ex_reg2);
            if (m_mis() && m_nm != 32'hFFFF_FFFF) m_nm++;
            if (ex_valid && ex_br_type != 3'd0) begin
                if (m_nb != 32'hFFFF_FFFF) m_nb++;
                hit = m_valid[idx] && m_tag[idx] == tg;
                if (hit) begin
                    if (b) begin
                        if (m_cnt[idx] < CMAX) m_cnt[idx]++;
                        m_tgt[idx] = ex_target;
                    end else if (m_cnt[idx] > 0) begin
                        m_cnt[idx]--;
                    end
                end else if (b) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = tg;
                    m_tgt[idx]   = ex_target;
                    m_cnt[idx]   = CTHRES;
                end
            end
            if (ex_valid && ex_br_type != 3'd0) chk_en = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            bit hit, et, eb;
            logic [31:0] etgt;
            idx  = int'((if_pc / 4) % ENTRIES);
            hit  = m_valid[idx] && m_tag[idx] == if_pc / (4 * ENTRIES);
            et   = rst_n && hit && (m_cnt[idx] >= CTHRES);
            etgt = et ? m_tgt[idx] : if_pc + 32'd4;
            eb   = m_resolve(int'(ex_br_type), ex_reg1, ex_reg2);
            check("cmp_pred_taken",  {31'd0, pred_taken},    {31'd0, et});
            check("cmp_pred_target", pred_target,            etgt);
            check("cmp_ex_br",       {31'd0, ex_br},         {31'd0, eb});
            check("cmp_mispredict",  {31'd0, ex_mispredict}, {31'd0, m_mis()});
            check("cmp_redirect",    ex_redirect_pc,         eb ? ex_target : ex_pc + 32'd4);
`ifdef BP_STATS_EN
            check("cmp_stat_br",  stat_branches,    m_nb);
            check("cmp_stat_mis", stat_mispredicts, m_nm);
`else
            check("cmp_stat_br",  stat_branches,    32'd0);
            check("cmp_stat_mis", stat_mispredicts, 32'd0);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic ex_drive(input logic [31:0] pc, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_pc = pc; ex_br_type = t; ex_reg1 = a; ex_reg2 = b;
        ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_pc = 32'h0; ex_br_type = NOBRANCH; ex_reg1 = 32'h0;
        ex_reg2 = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        ex_idle();
        @(posedge clk);
        chk_en = 1'b1;
        #1;
        adv();
        rst_n = 1'b1;

        // Post-reset lookup
        settle();
        check("reset_pred_taken",  {31'd0, pred_taken}, 32'd0);
        check("reset_pred_target", pred_target,         32'h104);
        adv();

        // BEQ taken, predicted not-taken; same-cycle lookup sees old contents
        ex_drive(32'h100, BEQ, 32'd5, 32'd5, 32'h80, 1'b0, 32'h104);
        settle();
        check("beq_br",        {31'd0, ex_br},         32'd1);
        check("beq_mis",       {31'd0, ex_mispredict}, 32'd1);
        check("beq_redirect",  ex_redirect_pc,         32'h80);
        check("same_cyc_miss", {31'd0, pred_taken},    32'd0);
        adv();
        ex_idle();
        settle();
        check("alloc_hit",    {31'd0, pred_taken}, 32'd1);
        check("alloc_target", pred_target,         32'h80);
`ifdef BP_STATS_EN
        check("stat_br_1",  stat_branches,    32'd1);
        check("stat_mis_1", stat_mispredicts, 32'd1);
`else
        check("stat_br_0",  stat_branches,    32'd0);
        check("stat_mis_0", stat_mispredicts, 32'd0);
`endif
        adv();

        // Signed vs unsigned compare
        ex_drive(32'h208, BLT, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b1, 32'h300);
        settle();
        check("blt_br",  {31'd0, ex_br},         32'd1);
        check("blt_mis", {31'd0, ex_mispredict}, 32'd0);
        adv();
        ex_drive(32'h20C, BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h210);
        settle();
        check("bltu_br",       {31'd0, ex_br},         32'd0);
        check("bltu_mis",      {31'd0, ex_mispredict}, 32'd0);
        check("bltu_redirect", ex_redirect_pc,         32'h210);
        adv();

        // Saturation: allocate, 3 more taken back-to-back, then not-taken twice
        if_pc = 32'h410;
        for (int unsigned i = 0; i < 4; i++) begin
            ex_drive(32'h410, BNE, 32'd1, 32'd2, 32'h480, 1'b1, 32'h480);
            adv();
        end
        ex_drive(32'h410, BGE, 32'd1, 32'd2, 32'h480, 1'b1, 32'h480);
        adv();
        ex_idle();
        settle();
        check("sat_one_nt", {31'd0, pred_taken}, 32'd1);
        adv();
        ex_drive(32'h410, BGE, 32'd1, 32'd2, 32'h480, 1'b1, 32'h480);
        adv();
        ex_idle();
        settle();
        check("sat_two_nt",        {31'd0, pred_taken}, 32'd0);
        check("sat_two_nt_target", pred_target,         32'h414);
        adv();

        // Aliasing: 0x200 shares an index with 0x100
        if_pc = 32'h100;
        settle();
        check("alias_before", {31'd0, pred_taken}, 32'd1);
        adv();
        ex_drive(32'h200, BGEU, 32'd5, 32'd5, 32'h500, 1'b0, 32'h204);
        adv();
        ex_idle();
        settle();
        check("alias_evicted", {31'd0, pred_taken}, 32'd0);
        check("alias_ev_tgt",  pred_target,         32'h104);
        adv();
        if_pc = 32'h200;
        settle();
        check("alias_new_tgt", pred_target, 32'h500);
        adv();

        // Non-branch / undefined codes predicted taken, wrong target, invalid slot
        ex_drive(32'h600, NOBRANCH, 32'd1, 32'd1, 32'h999, 1'b1, 32'h999);
        settle();
        check("nob_mis",      {31'd0, ex_mispredict}, 32'd1);
        check("nob_redirect", ex_redirect_pc,         32'h604);
        adv();
        ex_drive(32'h600, 3'd7, 32'd1, 32'd1, 32'h999, 1'b1, 32'h999);
        settle();
        check("undef_br", {31'd0, ex_br}, 32'd0);
        adv();
        ex_drive(32'h200, BEQ, 32'd5, 32'd5, 32'h504, 1'b1, 32'h500);
        settle();
        check("tgt_mis", {31'd0, ex_mispredict}, 32'd1);
        adv();
        ex_drive(32'h200, BEQ, 32'd5, 32'd5, 32'h504, 1'b0, 32'h0);
        ex_valid = 1'b0;
        settle();
        check("invalid_no_mis", {31'd0, ex_mispredict}, 32'd0);
        adv();
        ex_idle();

        // PC wrap
        if_pc = 32'hFFFF_FFFC;
        settle();
        check("pc_wrap", pred_target, 32'h0);
        adv();

        // Reset with a coincident update
        if_pc = 32'h200;
        rst_n = 1'b0;
        ex_drive(32'h700, BEQ, 32'd1, 32'd1, 32'h800, 1'b0, 32'h704);
        settle();
        check("rst_pred", {31'd0, pred_taken},    32'd0);
        check("rst_mis",  {31'd0, ex_mispredict}, 32'd0);
        adv();
        rst_n = 1'b1;
        ex_idle();
        settle();
        check("rst_cleared", {31'd0, pred_taken}, 32'd0);
        check("rst_stat",    stat_branches,       32'd0);
        adv();
        if_pc = 32'h700;
        settle();
        check("rst_discard", {31'd0, pred_taken}, 32'd0);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
